// File: rtl/dram_arbiter.sv
// Per-cycle arbiter sharing the single-port data DRAM between the CPU (m0) and the loader (m1); ARB_CPU_PRIO_EN selects CPU priority with m1 anti-starvation instead of round-robin.
// Latency: grant and DRAM command are combinational in the request cycle; read data and rvalid return exactly one cycle after the grant.
// Backpressure: a master holds req/we/addr/wdata until gnt; one access per cycle, fully pipelined, no request accepted without gnt.

module dram_arbiter #(
    parameter int AW         = 14,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic          cpu_clk,
    input  logic          cpu_rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic [AW-1:0] dram_addr,
    output logic [DW-1:0] dram_wdata,
    output logic          dram_we,
    input  logic [DW-1:0] dram_rd
);

    if (STARVE_MAX < 1) begin : g_bad_starve_max
        $error("dram_arbiter: STARVE_MAX must be at least 1");
    end

    logic       m0_win;
    logic       m1_win;
    logic       conflict_to_m1;
    logic [1:0] rd_pend_q;
    logic [1:0] rd_pend_d;

`ifdef ARB_CPU_PRIO_EN
    localparam int SCW = $clog2(STARVE_MAX + 1);

    logic [SCW-1:0] starve_q;
    logic [SCW-1:0] starve_d;

    // CPU wins conflicts until m1 has been refused STARVE_MAX cycles in a row.
    assign conflict_to_m1 = (starve_q == SCW'(STARVE_MAX));

    always_comb begin
        starve_d = starve_q;
        if (!m1_req || m1_win) begin
            starve_d = '0;
        end else if (starve_q != SCW'(STARVE_MAX)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    logic last_gnt_q;
    logic last_gnt_d;

    // last_gnt_q = 1 means m1 held the most recent grant; resets to m1 so m0 wins first.
    assign conflict_to_m1 = ~last_gnt_q;

    always_comb begin
        last_gnt_d = last_gnt_q;
        if (m1_win) begin
            last_gnt_d = 1'b1;
        end else if (m0_win) begin
            last_gnt_d = 1'b0;
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            last_gnt_q <= 1'b1;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end
`endif

    // No grant may be issued while reset is held, even with requests present.
    always_comb begin
        m0_win = 1'b0;
        m1_win = 1'b0;
        if (!cpu_rst) begin
            if (m0_req && m1_req) begin
                m1_win = conflict_to_m1;
                m0_win = ~conflict_to_m1;
            end else begin
                m0_win = m0_req;
                m1_win = m1_req;
            end
        end
    end

    assign m0_gnt = m0_win;
    assign m1_gnt = m1_win;

    always_comb begin
        dram_addr  = '0;
        dram_wdata = '0;
        dram_we    = 1'b0;
        if (m0_win) begin
            dram_addr  = m0_addr;
            dram_wdata = m0_wdata;
            dram_we    = m0_we;
        end else if (m1_win) begin
            dram_addr  = m1_addr;
            dram_wdata = m1_wdata;
            dram_we    = m1_we;
        end
    end

    assign rd_pend_d = {m1_win & ~m1_we, m0_win & ~m0_we};

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            rd_pend_q <= 2'b00;
        end else begin
            rd_pend_q <= rd_pend_d;
        end
    end

    // A read in flight when reset arrives is dropped rather than returned.
    assign m0_rvalid = rd_pend_q[0] & ~cpu_rst;
    assign m1_rvalid = rd_pend_q[1] & ~cpu_rst;
    assign m0_rdata  = m0_rvalid ? dram_rd : '0;
    assign m1_rdata  = m1_rvalid ? dram_rd : '0;

endmodule

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter: write-first DRAM model, directed literal cases, then random two-master traffic checked every cycle against a transaction-level model.

module tb_dram_arbiter;

    localparam int AW = 14;
    localparam int DW = 32;
    localparam int SM = 4;

    logic          cpu_clk = 1'b0;
    logic          cpu_rst;
    logic          m0_req, m0_we, m1_req, m1_we;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic [AW-1:0] dram_addr;
    logic [DW-1:0] dram_wdata;
    logic          dram_we;
    logic [DW-1:0] dram_rd;

    int n_pass  = 0;
    int n_total = 0;

    always #5 cpu_clk = ~cpu_clk;

    dram_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SM)) dut (
        .cpu_clk    (cpu_clk),
        .cpu_rst    (cpu_rst),
        .m0_req     (m0_req),
        .m0_we      (m0_we),
        .m0_addr    (m0_addr),
        .m0_wdata   (m0_wdata),
        .m0_gnt     (m0_gnt),
        .m0_rvalid  (m0_rvalid),
        .m0_rdata   (m0_rdata),
        .m1_req     (m1_req),
        .m1_we      (m1_we),
        .m1_addr    (m1_addr),
        .m1_wdata   (m1_wdata),
        .m1_gnt     (m1_gnt),
        .m1_rvalid  (m1_rvalid),
        .m1_rdata   (m1_rdata),
        .dram_addr  (dram_addr),
        .dram_wdata (dram_wdata),
        .dram_we    (dram_we),
        .dram_rd    (dram_rd)
    );

    // Unwritten DRAM words read as a known pattern; 0x010 holds 0xDEADBEEF.
    function automatic logic [DW-1:0] init_word(input int a);
        return (a == 'h10) ? 32'hDEADBEEF : (32'h5A00_0000 | 32'(a));
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", nm, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // DRAM macro: synchronous write-first, one-cycle read latency.
    logic [DW-1:0] dram_mem [int];
    always @(posedge cpu_clk) begin
        dram_rd <= dram_we ? dram_wdata
                 : (dram_mem.exists(int'(dram_addr)) ? dram_mem[int'(dram_addr)] : init_word(int'(dram_addr)));
        if (dram_we) dram_mem[int'(dram_addr)] = dram_wdata;
    end

    // Transaction-level reference: who wins, what the DRAM sees, what each master gets back.
    logic [DW-1:0] ref_mem [int];
    int            exp_last   = 1;
    int            exp_starve = 0;
    bit            pend_vld   = 1'b0;
    int            pend_who   = 0;
    logic [DW-1:0] pend_dat   = '0;

    function automatic logic [DW-1:0] ref_rd(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    always @(negedge cpu_clk) begin : model
        int            w;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        logic          ewe;
        bit            pv0, pv1;
        w = -1; ea = '0; ed = '0; ewe = 1'b0;
        if (!cpu_rst) begin
            if (m0_req && m1_req) begin
`ifdef ARB_CPU_PRIO_EN
                w = (exp_starve == SM) ? 1 : 0;
`else
                w = (exp_last == 1) ? 0 : 1;
`endif
            end else if (m0_req) begin
                w = 0;
            end else if (m1_req) begin
                w = 1;
            end
        end
        if (w == 0) begin
            ea = m0_addr; ed = m0_wdata; ewe = m0_we;
        end else if (w == 1) begin
            ea = m1_addr; ed = m1_wdata; ewe = m1_we;
        end
        pv0 = !cpu_rst && pend_vld && pend_who == 0;
        pv1 = !cpu_rst && pend_vld && pend_who == 1;
        chk("m0_gnt",     64'(m0_gnt),     64'(w == 0));
        chk("m1_gnt",     64'(m1_gnt),     64'(w == 1));
        chk("dram_addr",  64'(dram_addr),  64'(ea));
        chk("dram_wdata", 64'(dram_wdata), 64'(ed));
        chk("dram_we",    64'(dram_we),    64'(ewe));
        chk("m0_rvalid",  64'(m0_rvalid),  64'(pv0));
        chk("m1_rvalid",  64'(m1_rvalid),  64'(pv1));
        chk("m0_rdata",   64'(m0_rdata),   pv0 ? 64'(pend_dat) : 64'(0));
        chk("m1_rdata",   64'(m1_rdata),   pv1 ? 64'(pend_dat) : 64'(0));
        if (cpu_rst) begin
            exp_last = 1; exp_starve = 0; pend_vld = 1'b0;
        end else begin
            exp_starve = (m1_req && w != 1) ? exp_starve + 1 : 0;
            if (w >= 0) exp_last = w;
            pend_vld = (w >= 0) && !ewe;
            pend_who = w;
            if (pend_vld) pend_dat = ref_rd(int'(ea));
            else if (w >= 0) ref_mem[int'(ea)] = ed;
        end
    end

    task automatic step();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic set_m0(input logic r, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        m0_req = r; m0_we = we; m0_addr = a; m0_wdata = d;
    endtask

    task automatic set_m1(input logic r, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        m1_req = r; m1_we = we; m1_addr = a; m1_wdata = d;
    endtask

    initial begin : stim
        bit p0, p1;
        int ncyc;
        cpu_rst = 1'b1;
        set_m0(1'b1, 1'b0, 14'h005, 32'h0);
        set_m1(1'b1, 1'b1, 14'h006, 32'h1111);
        @(negedge cpu_clk);
        chk("rst_m0_gnt", 64'(m0_gnt), 64'(0));
        chk("rst_m1_gnt", 64'(m1_gnt), 64'(0));
        chk("rst_dram_we", 64'(dram_we), 64'(0));
        step();

        // m0 read of 0x010
        cpu_rst = 1'b0;
        set_m0(1'b1, 1'b0, 14'h010, 32'h0);
        set_m1(1'b0, 1'b0, 14'h000, 32'h0);
        @(negedge cpu_clk);
        chk("rd_gnt", 64'(m0_gnt), 64'(1));
        chk("rd_addr", 64'(dram_addr), 64'(14'h010));
        chk("rd_we", 64'(dram_we), 64'(0));
        step();
        set_m0(1'b0, 1'b0, 14'h000, 32'h0);
        @(negedge cpu_clk);
        chk("rd_rvalid", 64'(m0_rvalid), 64'(1));
        chk("rd_rdata", 64'(m0_rdata), 64'(32'hDEADBEEF));
        chk("rd_m1_rvalid", 64'(m1_rvalid), 64'(0));
        step();

        // m1 write then m0 read-back of 0x020
        set_m1(1'b1, 1'b1, 14'h020, 32'h0000_1234);
        @(negedge cpu_clk);
        chk("wr_m1_gnt", 64'(m1_gnt), 64'(1));
        chk("wr_we", 64'(dram_we), 64'(1));
        step();
        set_m1(1'b0, 1'b0, 14'h000, 32'h0);
        set_m0(1'b1, 1'b0, 14'h020, 32'h0);
        @(negedge cpu_clk);
        chk("raw_m0_gnt", 64'(m0_gnt), 64'(1));
        chk("raw_we", 64'(dram_we), 64'(0));
        step();
        set_m0(1'b0, 1'b0, 14'h000, 32'h0);
        @(negedge cpu_clk);
        chk("raw_rvalid", 64'(m0_rvalid), 64'(1));
        chk("raw_rdata", 64'(m0_rdata), 64'(32'h0000_1234));
        step();

        // Continuous conflict straight after reset
        cpu_rst = 1'b1;
        step();
        cpu_rst = 1'b0;
        set_m0(1'b1, 1'b0, 14'h100, 32'h0);
        set_m1(1'b1, 1'b0, 14'h200, 32'h0);
`ifdef ARB_CPU_PRIO_EN
        ncyc = 10;
`else
        ncyc = 6;
`endif
        for (int i = 0; i < ncyc; i++) begin
            bit exp_m1;
`ifdef ARB_CPU_PRIO_EN
            exp_m1 = (i % 5) == 4;
`else
            exp_m1 = (i % 2) == 1;
`endif
            @(negedge cpu_clk);
            chk($sformatf("pat_m1_gnt[%0d]", i), 64'(m1_gnt), 64'(exp_m1));
            chk($sformatf("pat_m0_gnt[%0d]", i), 64'(m0_gnt), 64'(!exp_m1));
            step();
        end
        set_m0(1'b0, 1'b0, 14'h000, 32'h0);
        set_m1(1'b0, 1'b0, 14'h000, 32'h0);
        step();

        // Reset arrives while an m1 read is pending
        set_m1(1'b1, 1'b0, 14'h030, 32'h0);
        @(negedge cpu_clk);
        chk("rstp_gnt", 64'(m1_gnt), 64'(1));
        step();
        set_m1(1'b0, 1'b0, 14'h000, 32'h0);
        cpu_rst = 1'b1;
        @(negedge cpu_clk);
        chk("rstp_rvalid_n1", 64'(m1_rvalid), 64'(0));
        chk("rstp_rdata_n1", 64'(m1_rdata), 64'(0));
        step();
        cpu_rst = 1'b0;
        @(negedge cpu_clk);
        chk("rstp_rvalid_n2", 64'(m1_rvalid), 64'(0));
        chk("rstp_m0_rvalid_n2", 64'(m0_rvalid), 64'(0));
        chk("rstp_gnt_n2", 64'({m0_gnt, m1_gnt}), 64'(0));
        chk("rstp_dram_n2", 64'({dram_we, dram_addr}), 64'(0));
        chk("rstp_wdata_n2", 64'(dram_wdata), 64'(0));
        step();

        // Pipelined m0 reads of 0x001..0x003
        for (int i = 1; i <= 4; i++) begin
            if (i <= 3) set_m0(1'b1, 1'b0, AW'(i), 32'h0);
            else        set_m0(1'b0, 1'b0, 14'h000, 32'h0);
            @(negedge cpu_clk);
            chk($sformatf("pipe_we[%0d]", i), 64'(dram_we), 64'(0));
            if (i <= 3) chk($sformatf("pipe_gnt[%0d]", i), 64'(m0_gnt), 64'(1));
            if (i >= 2) begin
                chk($sformatf("pipe_rvalid[%0d]", i), 64'(m0_rvalid), 64'(1));
                chk($sformatf("pipe_rdata[%0d]", i), 64'(m0_rdata), 64'(32'h5A00_0000 | 32'(i - 1)));
            end
            step();
        end

        // Random traffic: each master holds its request until granted
        p0 = 1'b0;
        p1 = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (!p0 && $urandom_range(0, 99) < 60) begin
                p0 = 1'b1;
                set_m0(1'b1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom);
            end
            if (!p1 && $urandom_range(0, 99) < 60) begin
                p1 = 1'b1;
                set_m1(1'b1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom);
            end
            m0_req  = p0;
            m1_req  = p1;
            cpu_rst = ($urandom_range(0, 299) == 0);
            @(negedge cpu_clk);
            if (m0_req && m0_gnt) p0 = 1'b0;
            if (m1_req && m1_gnt) p1 = 1'b0;
            step();
        end
        set_m0(1'b0, 1'b0, 14'h000, 32'h0);
        set_m1(1'b0, 1'b0, 14'h000, 32'h0);
        cpu_rst = 1'b0;
        step();
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
